// File: rtl/hazard_unit.sv
// hazard_unit: operand forwarding, load-use/control hazard stalls and flushes, data-memory wait FSM with timeout, event counters
module hazard_unit #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             LuiM,
  input  logic [1:0]       PCSrcE,
  input  logic             MemAccessM,
  input  logic             mem_ready,
  input  logic             clr_cnt,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_err,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic {RUN, MWAIT} state_t;
  state_t state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic ign_q, ign_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic tmo, mwait, load_use, ctrl;
  function automatic logic [1:0] fwd(input logic [4:0] rs, input logic [4:0] rd_m, input logic [4:0] rd_w,
                                     input logic we_m, input logic we_w, input logic lui);
    return (we_m && rd_m != 5'd0 && rd_m == rs) ? {1'b1, lui} :
           (we_w && rd_w != 5'd0 && rd_w == rs) ? 2'b01 : 2'b00;
  endfunction
  always_comb begin
    tmo = state_q == MWAIT && !mem_ready && wait_cnt_q == WW'(MEM_TIMEOUT - 1);
    mwait = (state_q == RUN) ? (MemAccessM && !mem_ready && !ign_q) : (!mem_ready && !tmo);
    load_use = ResultSrcE == 2'b01 && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
    ctrl = PCSrcE != 2'b00;
    StallF = rst && (mwait || (load_use && !ctrl));
    StallD = StallF;
    StallE = rst && mwait;
    StallM = StallE;
    FlushD = !rst || (!mwait && ctrl);
    FlushE = !rst || (!mwait && (ctrl || load_use));
    FlushW = !rst || mwait || tmo;
    ForwardAE = rst ? fwd(Rs1E, RdM, RdW, RegWriteM, RegWriteW, LuiM) : 2'b00;
    ForwardBE = rst ? fwd(Rs2E, RdM, RdW, RegWriteM, RegWriteW, LuiM) : 2'b00;
    mem_err = rst && tmo;
    busy = rst && state_q == MWAIT;
    state_d = mwait ? MWAIT : RUN;
    wait_cnt_d = (state_q == RUN) ? '0 : wait_cnt_q + 1'b1;
    ign_d = tmo;
    stall_cnt_d = clr_cnt ? '0 : (StallF && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = clr_cnt ? '0 : (FlushD && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    stall_cycles = stall_cnt_q;
    flush_cycles = flush_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      wait_cnt_q <= '0;
      ign_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ign_q <= ign_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and randomized checks of hazard_unit against a cycle-level reference model
module tb_hazard_unit;
  localparam int CNT_W = 4;
  localparam int MEM_TIMEOUT = 15;
  localparam int MAXC = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
  logic RegWriteM = 1'b0, RegWriteW = 1'b0, LuiM = 1'b0, MemAccessM = 1'b0, mem_ready = 1'b0, clr_cnt = 1'b0;
  logic [1:0] ResultSrcE = '0, PCSrcE = '0;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err, busy;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] stall_cycles, flush_cycles;
  int n_checks = 0;
  int n_pass = 0;
  bit m_wait = 1'b0;
  bit m_ign = 1'b0;
  int m_elapsed = 0;
  int m_sc = 0;
  int m_fc = 0;
  bit e_hold, e_sf, e_se, e_fd, e_fe, e_fw, e_err, e_busy;
  logic [1:0] e_fa, e_fb;
  hazard_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .LuiM(LuiM), .PCSrcE(PCSrcE),
    .MemAccessM(MemAccessM), .mem_ready(mem_ready), .clr_cnt(clr_cnt),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_err(mem_err), .busy(busy), .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
  );
  always #5 clk = ~clk;
  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return LuiM ? 2'd3 : 2'd2;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'd1;
    return 2'd0;
  endfunction
  task automatic model_eval();
    bit lu, br, tmo;
    tmo = m_wait && !mem_ready && m_elapsed == MEM_TIMEOUT;
    e_hold = m_wait ? (!mem_ready && !tmo) : (MemAccessM && !mem_ready && !m_ign);
    lu = ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    br = PCSrcE != 0;
    if (!rst) begin
      e_sf = 0; e_se = 0; e_fd = 1; e_fe = 1; e_fw = 1; e_fa = 0; e_fb = 0; e_err = 0; e_busy = 0;
    end else begin
      e_sf = e_hold || (lu && !br);
      e_se = e_hold;
      e_fd = !e_hold && br;
      e_fe = !e_hold && (br || lu);
      e_fw = e_hold || tmo;
      e_fa = fwd_ref(Rs1E);
      e_fb = fwd_ref(Rs2E);
      e_err = tmo;
      e_busy = m_wait;
    end
  endtask
  task automatic tick();
    model_eval();
    if (!rst) begin
      m_wait = 0; m_ign = 0; m_elapsed = 0; m_sc = 0; m_fc = 0;
    end else begin
      m_ign = e_err;
      m_elapsed = e_hold ? m_elapsed + 1 : 0;
      m_wait = e_hold;
      if (clr_cnt) begin
        m_sc = 0; m_fc = 0;
      end else begin
        if (e_sf) m_sc = (m_sc < MAXC) ? m_sc + 1 : MAXC;
        if (e_fd) m_fc = (m_fc < MAXC) ? m_fc + 1 : MAXC;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    rst = 1; clr_cnt = 0; Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; LuiM = 0; ResultSrcE = 0; PCSrcE = 0; MemAccessM = 0; mem_ready = 0;
  endtask
  task automatic clear_counters();
    idle(); clr_cnt = 1; tick(); clr_cnt = 0;
  endtask
  task automatic test_reset();
    rst = 0; MemAccessM = 1; PCSrcE = 1; ResultSrcE = 1; RdE = 3; Rs1D = 3; RegWriteM = 1; RdM = 4; Rs1E = 4; Rs2E = 4;
    #1;
    n_checks++; if ({StallF, StallD, StallE, StallM} !== 4'b0000) $display("FAIL rst_stalls: got %b want 0000", {StallF, StallD, StallE, StallM}); else n_pass++;
    n_checks++; if ({FlushD, FlushE, FlushW} !== 3'b111) $display("FAIL rst_flushes: got %b want 111", {FlushD, FlushE, FlushW}); else n_pass++;
    n_checks++; if ({ForwardAE, ForwardBE} !== 4'b0000) $display("FAIL rst_fwd: got %b want 0000", {ForwardAE, ForwardBE}); else n_pass++;
    n_checks++; if ({mem_err, busy} !== 2'b00) $display("FAIL rst_err_busy: got %b want 00", {mem_err, busy}); else n_pass++;
    tick(); tick();
    n_checks++; if (stall_cycles !== '0 || flush_cycles !== '0) $display("FAIL rst_counters: got %0d/%0d want 0/0", stall_cycles, flush_cycles); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy_after: got %b want 0", busy); else n_pass++;
    idle();
    tick();
  endtask
  task automatic test_forwarding();
    idle(); Rs1E = 5; Rs2E = 5; RdM = 5; RegWriteM = 1; LuiM = 0; RdW = 5; RegWriteW = 1;
    #1;
    n_checks++; if (ForwardAE !== 2'b10) $display("FAIL fwd_mem_alu: got %b want 10", ForwardAE); else n_pass++;
    n_checks++; if (ForwardBE !== 2'b10) $display("FAIL fwd_mem_alu_b: got %b want 10", ForwardBE); else n_pass++;
    LuiM = 1; #1;
    n_checks++; if (ForwardAE !== 2'b11) $display("FAIL fwd_mem_lui: got %b want 11", ForwardAE); else n_pass++;
    RdM = 0; #1;
    n_checks++; if (ForwardAE !== 2'b01) $display("FAIL fwd_wb_x0m: got %b want 01", ForwardAE); else n_pass++;
    n_checks++; if (ForwardBE !== 2'b01) $display("FAIL fwd_wb_b: got %b want 01", ForwardBE); else n_pass++;
    RegWriteW = 0; #1;
    n_checks++; if (ForwardAE !== 2'b00) $display("FAIL fwd_none: got %b want 00", ForwardAE); else n_pass++;
    RdM = 5; RegWriteW = 1; Rs2E = 7; RdW = 7; #1;
    n_checks++; if ({ForwardAE, ForwardBE} !== 4'b1101) $display("FAIL fwd_split: got %b want 1101", {ForwardAE, ForwardBE}); else n_pass++;
    idle();
    tick();
  endtask
  task automatic test_load_use();
    clear_counters();
    ResultSrcE = 2'b01; RdE = 0; Rs1D = 0; #1;
    n_checks++; if (StallF !== 1'b0) $display("FAIL lu_x0: got %b want 0", StallF); else n_pass++;
    RdE = 3; Rs1D = 1; Rs2D = 3; #1;
    n_checks++; if ({StallF, StallD, FlushE} !== 3'b111) $display("FAIL lu_resp: got %b want 111", {StallF, StallD, FlushE}); else n_pass++;
    n_checks++; if ({StallE, StallM, FlushD, FlushW} !== 4'b0000) $display("FAIL lu_others: got %b want 0000", {StallE, StallM, FlushD, FlushW}); else n_pass++;
    tick(); idle(); #1;
    n_checks++; if (stall_cycles !== 4'd1) $display("FAIL lu_count: got %0d want 1", stall_cycles); else n_pass++;
    n_checks++; if (StallF !== 1'b0) $display("FAIL lu_release: got %b want 0", StallF); else n_pass++;
  endtask
  task automatic test_branch();
    clear_counters();
    PCSrcE = 2'b01; ResultSrcE = 2'b01; RdE = 3; Rs2D = 3; #1;
    n_checks++; if ({FlushD, FlushE} !== 2'b11) $display("FAIL br_flush: got %b want 11", {FlushD, FlushE}); else n_pass++;
    n_checks++; if ({StallF, StallD} !== 2'b00) $display("FAIL br_nostall: got %b want 00", {StallF, StallD}); else n_pass++;
    tick(); idle(); #1;
    n_checks++; if (flush_cycles !== 4'd1 || stall_cycles !== 4'd0) $display("FAIL br_counts: got %0d/%0d want 1/0", flush_cycles, stall_cycles); else n_pass++;
  endtask
  task automatic test_mem_wait();
    clear_counters();
    MemAccessM = 1; mem_ready = 0; PCSrcE = 2'b01; ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if ({StallF, StallD, StallE, StallM, FlushW} !== 5'b11111) $display("FAIL mw_stall%0d: got %b want 11111", i, {StallF, StallD, StallE, StallM, FlushW}); else n_pass++;
      n_checks++; if ({FlushD, FlushE} !== 2'b00) $display("FAIL mw_override%0d: got %b want 00", i, {FlushD, FlushE}); else n_pass++;
      n_checks++; if (busy !== (i > 0)) $display("FAIL mw_busy%0d: got %b want %b", i, busy, i > 0); else n_pass++;
      tick();
    end
    mem_ready = 1; PCSrcE = 0; ResultSrcE = 0; #1;
    n_checks++; if ({StallF, StallD, StallE, StallM} !== 4'b0000) $display("FAIL mw_release: got %b want 0000", {StallF, StallD, StallE, StallM}); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL mw_busy_rel: got %b want 1", busy); else n_pass++;
    tick(); idle(); #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL mw_busy_end: got %b want 0", busy); else n_pass++;
    n_checks++; if (stall_cycles !== 4'd3 || flush_cycles !== 4'd0) $display("FAIL mw_counts: got %0d/%0d want 3/0", stall_cycles, flush_cycles); else n_pass++;
  endtask
  task automatic test_timeout();
    clear_counters();
    MemAccessM = 1; mem_ready = 0;
    for (int i = 0; i <= MEM_TIMEOUT; i++) begin
      #1;
      n_checks++; if (mem_err !== (i == MEM_TIMEOUT)) $display("FAIL to_err%0d: got %b want %b", i, mem_err, i == MEM_TIMEOUT); else n_pass++;
      if (i == MEM_TIMEOUT) begin
        n_checks++; if ({StallF, StallE, FlushW} !== 3'b001) $display("FAIL to_squash: got %b want 001", {StallF, StallE, FlushW}); else n_pass++;
      end
      tick();
    end
    #1;
    n_checks++; if ({StallF, busy, mem_err} !== 3'b000) $display("FAIL to_noreentry: got %b want 000", {StallF, busy, mem_err}); else n_pass++;
    tick(); #1;
    n_checks++; if (StallF !== 1'b1) $display("FAIL to_reentry: got %b want 1", StallF); else n_pass++;
    tick(); mem_ready = 1; #1;
    n_checks++; if (busy !== 1'b1 || StallF !== 1'b0) $display("FAIL to_rel: got busy %b stall %b want 1 0", busy, StallF); else n_pass++;
    tick(); idle(); #1;
    n_checks++; if (stall_cycles !== 4'(MAXC)) $display("FAIL to_count: got %0d want %0d", stall_cycles, MAXC); else n_pass++;
  endtask
  task automatic test_reset_in_wait();
    idle(); MemAccessM = 1; mem_ready = 0;
    tick(); tick(); #1;
    n_checks++; if (busy !== 1'b1) $display("FAIL rw_busy: got %b want 1", busy); else n_pass++;
    rst = 0; #1;
    n_checks++; if ({mem_err, busy, StallF} !== 3'b000) $display("FAIL rw_abandon: got %b want 000", {mem_err, busy, StallF}); else n_pass++;
    tick(); rst = 1; MemAccessM = 0; #1;
    n_checks++; if ({busy, mem_err} !== 2'b00 || stall_cycles !== '0) $display("FAIL rw_after: got %b cnt %0d want 00 cnt 0", {busy, mem_err}, stall_cycles); else n_pass++;
    tick();
  endtask
  task automatic test_saturation();
    clear_counters();
    ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
    repeat (20) tick();
    n_checks++; if (stall_cycles !== 4'(MAXC)) $display("FAIL sat_stall: got %0d want %0d", stall_cycles, MAXC); else n_pass++;
    ResultSrcE = 0; PCSrcE = 2'b10;
    repeat (20) tick();
    n_checks++; if (flush_cycles !== 4'(MAXC)) $display("FAIL sat_flush: got %0d want %0d", flush_cycles, MAXC); else n_pass++;
    PCSrcE = 0; ResultSrcE = 2'b01; clr_cnt = 1; #1;
    n_checks++; if (StallF !== 1'b1) $display("FAIL clr_stallcyc: got %b want 1", StallF); else n_pass++;
    tick(); idle(); #1;
    n_checks++; if (stall_cycles !== '0 || flush_cycles !== '0) $display("FAIL clr_prio: got %0d/%0d want 0/0", stall_cycles, flush_cycles); else n_pass++;
  endtask
  task automatic test_random();
    logic [12:0] got, exp;
    for (int c = 0; c < 600; c++) begin
      rst = $urandom_range(0, 39) != 0;
      clr_cnt = $urandom_range(0, 24) == 0;
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1)); LuiM = 1'($urandom_range(0, 1));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      MemAccessM = 1'($urandom_range(0, 1));
      mem_ready = (c % 200 < 60) ? 1'b0 : ($urandom_range(0, 3) == 0);
      #1;
      model_eval();
      got = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE, mem_err, busy};
      exp = {e_sf, e_sf, e_se, e_se, e_fd, e_fe, e_fw, e_fa, e_fb, e_err, e_busy};
      n_checks++; if (got !== exp) $display("FAIL rnd_out%0d: got %b want %b", c, got, exp); else n_pass++;
      n_checks++; if (stall_cycles !== CNT_W'(m_sc) || flush_cycles !== CNT_W'(m_fc)) $display("FAIL rnd_cnt%0d: got %0d/%0d want %0d/%0d", c, stall_cycles, flush_cycles, m_sc, m_fc); else n_pass++;
      tick();
    end
  endtask
  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_in_wait();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
